// File: rtl/uart_pkg.sv
// Definitions shared by the uart transmitter and receiver: FSM states, default
// frame geometry and a counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, parallel word and status out.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = uart_pkg::UART_DATA_BITS
);
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rxd,
        output rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        output rxd,
        input  rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line (resets to idle-high) with a
// falling-edge strobe derived from the synchronized value.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxd_s = sync_q;
    assign fall  = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start, data (LSB first), optional parity
// and stop bits, with registered one-cycle status pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input logic       clk,
    input logic       rst_n,
    uart_rx_if.master bus
);
    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BW = cnt_width(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    logic                 rxd_s;
    logic                 fall;
    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 busy_q;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (bus.rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    // cnt_q restarts at each sample point, so every compare below marks a mid-bit instant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (fall) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        par_q   <= rxd_s;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        data_q  <= shift_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (rxd_s) begin
                            valid_q <= 1'b1;
                            perr_q  <= (PARITY_EN != 0) && (((^shift_q) ^ par_q) != ODD);
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level timing model checked every cycle against two
// receivers (no parity, even parity), plus literal latency/data checks.
module tb_uart_rx;
    localparam int C = 16;
    localparam int H = C / 2;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    bit       exp_v   [2][N];
    bit       exp_pe  [2][N];
    bit       exp_fe  [2][N];
    bit       exp_b   [2][N];
    bit       exp_ldf [2][N];
    bit [7:0] exp_ld  [2][N];
    bit [7:0] mdl_data[2];
    int       last_v  [2];

    uart_rx_if #(.DATA_BITS(8)) u0 ();
    uart_rx_if #(.DATA_BITS(8)) u1 ();

    uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(u0)
    );
    uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(u1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    // Frame timing from the line's point of view: rxd_s sees the fall 2 cycles
    // after the pin; stop sample is H + (data+parity+1)*C later; pulses follow by 1.
    task automatic model_frame(input int d, input int p, input bit [7:0] data,
                               input bit pen, input bit pbit, input bit stop);
        int t0, last;
        t0   = p + 2;
        last = t0 + H + (9 + int'(pen)) * C;
        for (int c = t0 + 1; c <= last; c++) exp_b[d][c] = 1'b1;
        exp_ldf[d][last + 1] = 1'b1;
        exp_ld[d][last + 1]  = data;
        if (stop) begin
            exp_v[d][last + 1]  = 1'b1;
            exp_pe[d][last + 1] = pen && (((^data) ^ pbit) != 1'b0);
        end else begin
            exp_fe[d][last + 1] = 1'b1;
        end
    endtask

    task automatic set_rxd(input int d, input logic v);
        if (d == 0) u0.rxd = v;
        else        u1.rxd = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int d, input logic v);
        set_rxd(d, v);
        idle(C);
    endtask

    task automatic send(input int d, input bit [7:0] data, input bit pen, input bit pbit,
                        input bit stop, output int p);
        p = cyc;
        model_frame(d, p, data, pen, pbit, stop);
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
        if (pen) drive_bit(d, pbit);
        drive_bit(d, stop);
    endtask

    always @(negedge clk) begin
        logic [7:0] od;
        logic ov, ope, ofe, ob;
        if (!rst_n) begin
            mdl_data[0] = '0;
            mdl_data[1] = '0;
        end else if (cyc < N) begin
            for (int d = 0; d < 2; d++) begin
                if (exp_ldf[d][cyc]) mdl_data[d] = exp_ld[d][cyc];
                if (d == 0) begin
                    od = u0.rx_data; ov = u0.rx_valid; ope = u0.parity_err; ofe = u0.frame_err; ob = u0.busy;
                end else begin
                    od = u1.rx_data; ov = u1.rx_valid; ope = u1.parity_err; ofe = u1.frame_err; ob = u1.busy;
                end
                if (ov === 1'b1) last_v[d] = cyc;
                if (chk_en) begin
                    chk("rx_data", d, 32'(od), 32'(mdl_data[d]));
                    chk("rx_valid", d, 32'(ov), 32'(exp_v[d][cyc]));
                    chk("parity_err", d, 32'(ope), 32'(exp_pe[d][cyc]));
                    chk("frame_err", d, 32'(ofe), 32'(exp_fe[d][cyc]));
                    chk("busy", d, 32'(ob), 32'(exp_b[d][cyc]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, p1, v1, t0;
        u0.rxd = 1'b1;
        u1.rxd = 1'b1;
        last_v[0] = 0;
        last_v[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 0, 32'(u0.rx_data), 32'h0);
        chk("reset_busy", 0, 32'(u0.busy), 32'h0);
        chk("reset_valid", 1, 32'(u1.rx_valid), 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(5);

        // 0xA5, good stop: pulse 2 + 8 + 9*16 + 1 cycles after the pin falls
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, p);
        idle(2 * C);
        chk("a5_latency", 0, 32'(last_v[0] - p), 32'd155);
        chk("a5_data", 0, 32'(u0.rx_data), 32'hA5);

        // 3-cycle glitch: busy only during the start-bit check
        p = cyc;
        t0 = p + 2;
        for (int c = t0 + 1; c <= t0 + H; c++) exp_b[0][c] = 1'b1;
        set_rxd(0, 1'b0);
        idle(3);
        set_rxd(0, 1'b1);
        idle(2 * C);
        chk("glitch_data", 0, 32'(u0.rx_data), 32'hA5);

        // framing error, then a recovery frame
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, p);
        idle(C);
        chk("ferr_data", 0, 32'(u0.rx_data), 32'h3C);
        set_rxd(0, 1'b1);
        idle(2 * C);
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, p);
        idle(2 * C);
        chk("recover_data", 0, 32'(u0.rx_data), 32'h81);

        // back-to-back with zero idle
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, p1);
        v1 = last_v[0];
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1, p);
        idle(2 * C);
        chk("b2b_first_lat", 0, 32'(v1 - p1), 32'd155);
        chk("b2b_gap", 0, 32'(last_v[0] - v1), 32'd160);
        chk("b2b_data", 0, 32'(u0.rx_data), 32'hFF);

        // even parity: 0x07 has three ones, so parity bit 1 is correct
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, p);
        idle(2 * C);
        chk("par_ok_lat", 1, 32'(last_v[1] - p), 32'd171);
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, p);
        idle(2 * C);
        chk("par_bad_data", 1, 32'(u1.rx_data), 32'h07);

        // reset during data bit 4 aborts the frame silently
        chk_en = 1'b0;
        set_rxd(0, 1'b0);
        idle(C);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'(i % 2));
        set_rxd(0, 1'b1);
        idle(H);
        chk("abort_busy_before", 0, 32'(u0.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 0, 32'(u0.busy), 32'h0);
        chk("abort_data", 0, 32'(u0.rx_data), 32'h0);
        chk("abort_valid", 0, 32'(u0.rx_valid), 32'h0);
        chk("abort_ferr", 0, 32'(u0.frame_err), 32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(4);
        chk_en = 1'b1;
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, p);
        idle(2 * C);
        chk("post_reset_lat", 0, 32'(last_v[0] - p), 32'd155);
        chk("post_reset_data", 0, 32'(u0.rx_data), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
